// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared constants and FSM state type for the neuron feeder
// Contents: DATA_W (pair element width), DEF_M / DEF_N (default pair count and
// result width), state_e (feeder FSM states).
package neuron_pkg;

  localparam int DATA_W = 8;
  localparam int DEF_M  = 4;
  localparam int DEF_N  = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/neuron_pair_mem.sv
// rtl/neuron_pair_mem.sv - M-entry register file holding {input, weight} pairs
// Ports:
//   clk_i, rst_i     clock, synchronous active-high clear of every slot
//   wr_en_i          write strobe (already qualified by the caller's busy state)
//   wr_addr_i        write slot; addresses >= M are dropped here
//   wr_data_i        {input, weight}
//   rd_addr_i        combinational read slot
//   rd_data_o        {input, weight} of rd_addr_i
module neuron_pair_mem
  import neuron_pkg::*;
#(
  parameter int M  = DEF_M,
  parameter int AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [2*DATA_W-1:0]   wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [2*DATA_W-1:0]   rd_data_o
);

  // One extra bit so M itself is representable for the range check.
  localparam logic [AW:0] M_L = (AW+1)'(M);

  logic [2*DATA_W-1:0] mem_q [M];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && ({1'b0, wr_addr_i} < M_L)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/neuron_feeder.sv
// rtl/neuron_feeder.sv - sequences buffered input/weight pairs into a neuron and captures its result
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   wr_en_i, wr_addr_i                host write into the pair buffer (idle only)
//   wr_in_i, wr_weight_i              pair value written
//   go_i                              start one evaluation (ignored while busy)
//   busy_o, done_o                    run in progress, one-cycle completion pulse
//   result_o, err_o                   last captured neuron output, timeout flag
//   n_start_o, n_in_o, n_weight_o     drive side to the neuron
//   n_out_i, n_ready_i                neuron result and result-valid
module neuron_feeder
  import neuron_pkg::*;
#(
  parameter int M       = DEF_M,
  parameter int N       = DEF_N,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 64,
  parameter int AW      = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_in_i,
  input  logic [DATA_W-1:0] wr_weight_i,
  input  logic              go_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [N-1:0]      result_o,
  output logic              err_o,
  output logic              n_start_o,
  output logic [DATA_W-1:0] n_in_o,
  output logic [DATA_W-1:0] n_weight_o,
  input  logic [N-1:0]      n_out_i,
  input  logic              n_ready_i
);

  localparam logic [3:0]    HOLD_LAST = 4'(HOLD - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(M - 1);
  localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [3:0]        hold_q, hold_d;
  logic [7:0]        wait_q, wait_d;
  logic [N-1:0]      result_q, result_d;
  logic              err_q, err_d;

  logic [2*DATA_W-1:0] rd_data;
  logic                mem_we;

  // Busy is derived from the state, so it rises on the go-acceptance edge and
  // falls on the edge that returns the FSM to IDLE.
  assign busy_o = (state_q != ST_IDLE);

  // The buffer is frozen for the whole run; a write in the go cycle still lands
  // because busy is low during that cycle.
  assign mem_we = wr_en_i & ~busy_o;

  neuron_pair_mem #(
    .M  (M),
    .AW (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_addr_i),
    .wr_data_i ({wr_in_i, wr_weight_i}),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      wait_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        idx_d   = '0;
        hold_d  = '0;
        wait_d  = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (idx_q == IDX_LAST) begin
            wait_d  = '0;
            state_d = ST_WAIT;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      ST_WAIT: begin
        // A ready already high on the first WAIT cycle is captured right away.
        if (n_ready_i) begin
          result_d = n_out_i;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        hold_d  = '0;
        wait_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign done_o     = (state_q == ST_DONE);
  assign n_start_o  = (state_q == ST_START);
  assign n_in_o     = (state_q == ST_FEED) ? rd_data[2*DATA_W-1:DATA_W] : '0;
  assign n_weight_o = (state_q == ST_FEED) ? rd_data[DATA_W-1:0] : '0;
  assign result_o   = result_q;
  assign err_o      = err_q;

endmodule
